mc_exception_unit: RTL and testbench

//  Parametrised exception/interrupt unit for the multi-cycle MIPS core; replaces the single EPC register and fixed 0x7c handler.

---
 rtl/mc_exc_pkg.sv | 12 +
 rtl/mc_exc_stack.sv | 41 ++++
 rtl/mc_exception_unit.sv | 89 ++++++++
 tb/tb_mc_exception_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mc_exc_pkg.sv
// mc_exc_pkg: cause codes, FSM state and stack entry type shared by the exception unit
package mc_exc_pkg;
  localparam logic [3:0] CAUSE_OVF = 4'd0;
  localparam logic [3:0] CAUSE_UNDEF = 4'd1;
  localparam logic [3:0] CAUSE_IRQ0 = 4'd2;
  localparam logic [3:0] CAUSE_FATAL = 4'd15;
  typedef enum logic [0:0] {RUN = 1'b0, TRAP = 1'b1} state_t;
  typedef struct packed {
    logic [31:0] epc;
    logic [3:0]  lvl;
  } stk_entry_t;
endpackage

// File: rtl/mc_exc_stack.sv
// mc_exc_stack: LIFO of {epc, level} used to nest exception handlers
module mc_exc_stack import mc_exc_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  stk_entry_t                   din,
  output logic                         full,
  output logic                         empty,
  output stk_entry_t                   top,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  stk_entry_t mem_q [DEPTH];
  stk_entry_t mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  // Entries are matched by comparing the count, avoiding out-of-range indexing.
  always_comb begin
    mem_d = mem_q;
    top = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (push && !full && cnt_q == CW'(e)) mem_d[e] = din;
      if (cnt_q == CW'(e + 1)) top = mem_q[e];
    end
    cnt_d = (push && !full) ? cnt_q + 1'b1 : (pop && !empty) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mc_exception_unit.sv
// mc_exception_unit: prioritised, maskable, nestable exception/interrupt unit for the multi-cycle core
module mc_exception_unit import mc_exc_pkg::*; #(
  parameter int          NUM_IRQ      = 4,
  parameter int          EPC_DEPTH    = 2,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0080,
  parameter int          VEC_STRIDE   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_IRQ-1:0]               irq,
  input  logic                             irq_mask_wr,
  input  logic [NUM_IRQ-1:0]               irq_mask_data,
  input  logic                             ovf_check,
  input  logic                             overflow,
  input  logic                             undef_op,
  input  logic                             instr_boundary,
  input  logic [31:0]                      pc_cur,
  input  logic                             eret,
  output logic                             take_exc,
  output logic [31:0]                      vector,
  output logic [3:0]                       cause,
  output logic [NUM_IRQ-1:0]               irq_ack,
  output logic [31:0]                      epc,
  output logic [$clog2(EPC_DEPTH+1)-1:0]   nest_depth,
  output logic                             stack_ovf
);
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, irq_ack_q, irq_ack_d, pend;
  logic [3:0] cause_q, cause_d, idx, lvl_new;
  logic [31:0] vector_q, vector_d;
  logic stack_ovf_q, stack_ovf_d, run, ovf, sync, any, irq_ok, take, push, pop, full, empty;
  stk_entry_t din, top;
  mc_exc_stack #(.DEPTH(EPC_DEPTH)) u_stack (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .top(top), .count(nest_depth)
  );
  always_comb begin
    pend = irq & ~mask_q;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = 4'(i);
        any = 1'b1;
      end
    end
    lvl_new = idx + 4'd1;
    run = state_q == RUN;
    ovf = ovf_check & overflow;
    sync = ovf | undef_op;
    // A concurrent eret defers irq detection so it is judged against the popped level.
    irq_ok = instr_boundary & any & ~eret & ~full & (empty | (lvl_new < top.lvl));
    take = run & (sync | irq_ok);
    push = take & ~(sync & full);
    pop = run & eret & ~sync;
    din.epc = pc_cur;
    din.lvl = sync ? 4'd0 : lvl_new;
    cause_d = !take ? cause_q : (sync & full) ? CAUSE_FATAL : ovf ? CAUSE_OVF :
              sync ? CAUSE_UNDEF : CAUSE_IRQ0 + idx;
    vector_d = take ? HANDLER_BASE + 32'(cause_d) * 32'(VEC_STRIDE) : vector_q;
    irq_ack_d = (take & ~sync) ? NUM_IRQ'(1) << idx : '0;
    stack_ovf_d = stack_ovf_q | (take & sync & full);
    mask_d = irq_mask_wr ? irq_mask_data : mask_q;
    state_d = take ? TRAP : RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      mask_q <= '1;
      irq_ack_q <= '0;
      cause_q <= CAUSE_OVF;
      vector_q <= HANDLER_BASE;
      stack_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      irq_ack_q <= irq_ack_d;
      cause_q <= cause_d;
      vector_q <= vector_d;
      stack_ovf_q <= stack_ovf_d;
    end
  end
  assign take_exc = state_q == TRAP;
  assign vector = vector_q;
  assign cause = cause_q;
  assign irq_ack = irq_ack_q;
  assign epc = top.epc;
  assign stack_ovf = stack_ovf_q;
endmodule

// File: tb/tb_mc_exception_unit.sv
// tb_mc_exception_unit: directed stimulus with a queue-based scoreboard checked on every take_exc pulse
module tb_mc_exception_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] irq = '0, irq_mask_data = '0, irq_ack, cause;
  logic irq_mask_wr = 0, ovf_check = 0, overflow = 0, undef_op = 0, instr_boundary = 0, eret = 0;
  logic [31:0] pc_cur = '0, vector, epc;
  logic take_exc, stack_ovf;
  logic [1:0] nest_depth;
  int n_tests = 0, n_fail = 0;
  typedef struct packed {
    logic [3:0]  cause;
    logic [31:0] vec;
    logic [3:0]  ack;
    logic [31:0] epc;
    logic [1:0]  depth;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  mc_exception_unit dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask_wr(irq_mask_wr), .irq_mask_data(irq_mask_data),
    .ovf_check(ovf_check), .overflow(overflow), .undef_op(undef_op), .instr_boundary(instr_boundary),
    .pc_cur(pc_cur), .eret(eret), .take_exc(take_exc), .vector(vector), .cause(cause),
    .irq_ack(irq_ack), .epc(epc), .nest_depth(nest_depth), .stack_ovf(stack_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_trap(input logic [3:0] c, input logic [31:0] v, input logic [3:0] a,
                             input logic [31:0] e, input logic [1:0] d, input logic o);
    exp_q.push_back('{cause: c, vec: v, ack: a, epc: e, depth: d, ovf: o});
  endtask

  // Monitor: every take_exc pulse must match the oldest expected trap.
  always @(negedge clk) begin
    if (!reset && take_exc) begin
      exp_t act, ex;
      act = '{cause: cause, vec: vector, ack: irq_ack, epc: epc, depth: nest_depth, ovf: stack_ovf};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_take: got %h expected no take_exc", act);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          n_fail++;
          $display("FAIL trap: got %h expected %h", act, ex);
        end
      end
    end
  end

  initial begin
    cyc(2);
    reset = 1'b0;
    chk("rst_take", 64'(take_exc), 64'd0);
    chk("rst_vector", 64'(vector), 64'h80);
    chk("rst_cause_ack", 64'({cause, irq_ack}), 64'd0);
    chk("rst_epc_depth", 64'({epc, nest_depth, stack_ovf}), 64'd0);
    // Undef trap, then reset asserted while in TRAP
    undef_op = 1; pc_cur = 32'h10;
    expect_trap(4'd1, 32'h88, 4'b0000, 32'h10, 2'd1, 1'b0);
    cyc(1);
    undef_op = 0;
    #6 reset = 1'b1;
    #1;
    chk("midtrap_take", 64'(take_exc), 64'd0);
    chk("midtrap_epc_depth", 64'({epc, nest_depth}), 64'd0);
    chk("midtrap_vector", 64'(vector), 64'h80);
    cyc(1);
    reset = 1'b0;
    // Unmask all, take irq2
    irq_mask_wr = 1; irq_mask_data = 4'b0000;
    cyc(1);
    irq_mask_wr = 0; irq = 4'b0100; instr_boundary = 1; pc_cur = 32'h40;
    expect_trap(4'd4, 32'hA0, 4'b0100, 32'h40, 2'd1, 1'b0);
    cyc(1); irq = 0; cyc(1);
    // Lower priority irq3 must not preempt
    irq = 4'b1000; cyc(1); irq = 0; cyc(1);
    chk("irq3_blocked_depth", 64'(nest_depth), 64'd1);
    irq = 4'b0001; pc_cur = 32'h90;
    expect_trap(4'd2, 32'h90, 4'b0001, 32'h90, 2'd2, 1'b0);
    cyc(1); irq = 0; cyc(1);
    eret = 1; cyc(1); eret = 0;
    chk("eret_epc", 64'(epc), 64'h40);
    chk("eret_depth", 64'(nest_depth), 64'd1);
    // Overflow beats undef and pending irq, without boundary
    ovf_check = 1; overflow = 1; undef_op = 1; instr_boundary = 0; irq = 4'b0001; pc_cur = 32'h100;
    expect_trap(4'd0, 32'h80, 4'b0000, 32'h100, 2'd2, 1'b0);
    cyc(1); ovf_check = 0; overflow = 0; undef_op = 0; irq = 0; cyc(1);
    // Full stack: fatal trap, no push
    undef_op = 1; pc_cur = 32'h200;
    expect_trap(4'd15, 32'hF8, 4'b0000, 32'h100, 2'd2, 1'b1);
    cyc(1); undef_op = 0; cyc(1);
    irq = 4'b0001; instr_boundary = 1; cyc(2); irq = 0;
    chk("full_depth", 64'(nest_depth), 64'd2);
    chk("full_ovf", 64'(stack_ovf), 64'd1);
    eret = 1; cyc(1); eret = 0; cyc(1);
    chk("pop1_epc", 64'(epc), 64'h40);
    eret = 1; cyc(1); eret = 0; cyc(1);
    eret = 1; cyc(1); eret = 0;
    chk("underflow_depth", 64'(nest_depth), 64'd0);
    chk("underflow_epc", 64'(epc), 64'd0);
    // Masked line ignored, next line taken
    irq_mask_wr = 1; irq_mask_data = 4'b0001; cyc(1); irq_mask_wr = 0;
    irq = 4'b0001; cyc(2); irq = 0;
    chk("masked_depth", 64'(nest_depth), 64'd0);
    irq = 4'b0011; pc_cur = 32'h50;
    expect_trap(4'd3, 32'h98, 4'b0010, 32'h50, 2'd1, 1'b1);
    cyc(1); irq = 0; cyc(1);
    // eret together with sync trap: trap wins, eret discarded
    eret = 1; undef_op = 1; pc_cur = 32'h300;
    expect_trap(4'd1, 32'h88, 4'b0000, 32'h300, 2'd2, 1'b1);
    cyc(1); eret = 0; undef_op = 0; cyc(1);
    chk("eret_sync_depth", 64'(nest_depth), 64'd2);
    cyc(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
